// File: rtl/lamp_arb_pkg.sv
// Shared types and width helpers for the lamp zone power arbiter.
package lamp_arb_pkg;

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_SETTLE = 1'b1
  } arb_state_t;

  // Widths for the default four-zone build; parameterised modules use the helpers below.
  localparam int unsigned N_ZONES_DFLT = 4;
  localparam int unsigned ZONE_W       = $clog2(N_ZONES_DFLT);
  localparam int unsigned CNT_W        = $clog2(N_ZONES_DFLT + 1);

  function automatic int unsigned zone_w(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  function automatic int unsigned cnt_w(input int unsigned n);
    return $clog2(n + 1);
  endfunction

  function automatic int unsigned popcnt(input logic [31:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < 32; i++) begin
      n += 32'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/zone_rr_picker.sv
// Combinational round-robin first-one finder: searches upward from rr_ptr, wrapping.
module zone_rr_picker
  import lamp_arb_pkg::*;
#(
  parameter  int unsigned N_ZONES = 4,
  localparam int unsigned ZW      = zone_w(N_ZONES)
) (
  input  logic [N_ZONES-1:0] cand,
  input  logic [ZW-1:0]      rr_ptr,
  output logic               valid,
  output logic [ZW-1:0]      index
);

  always_comb begin
    int unsigned j;
    logic [ZW-1:0] idx;
    valid = 1'b0;
    index = '0;
    for (int unsigned k = 0; k < N_ZONES; k++) begin
      j   = (32'(rr_ptr) + k) % N_ZONES;
      idx = ZW'(j);
      if (!valid && cand[idx]) begin
        valid = 1'b1;
        index = idx;
      end
    end
  end

endmodule

// File: rtl/lamp_zone_arbiter.sv
// Shares a lamp-power budget between zones: capacity limit, staggered turn-on,
// manual-over-automatic priority with round-robin tie breaking.
module lamp_zone_arbiter
  import lamp_arb_pkg::*;
#(
  parameter int unsigned N_ZONES   = 4,
  parameter int unsigned MAX_ON    = 2,
  parameter int unsigned STAGGER_T = 100
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [N_ZONES-1:0]           req,
  input  logic [N_ZONES-1:0]           manual,
  output logic [N_ZONES-1:0]           grant,
  output logic [N_ZONES-1:0]           pending,
  output logic                         busy,
  output logic [$clog2(N_ZONES+1)-1:0] on_count
);

  localparam int unsigned ZW = zone_w(N_ZONES);
  localparam int unsigned CW = cnt_w(N_ZONES);
  localparam int unsigned SW = $clog2(STAGGER_T);
  // SETTLE lasts STAGGER_T-1 cycles so the next IDLE decision lands exactly STAGGER_T after the last grant edge.
  localparam logic [SW-1:0] SETTLE_LOAD = SW'(STAGGER_T - 2);

  arb_state_t        state_q, state_d;
  logic [N_ZONES-1:0] grant_d;
  logic [ZW-1:0]     rr_q, rr_d;
  logic [SW-1:0]     cnt_q, cnt_d;
  logic              busy_d;
  logic [CW-1:0]     on_count_d;

  logic [N_ZONES-1:0] release_v;
  logic [N_ZONES-1:0] man_cand, auto_cand;
  logic               man_valid, auto_valid, win_valid, cap_ok;
  logic [ZW-1:0]      man_idx, auto_idx, win_idx;

  assign pending   = req & ~grant;
  assign release_v = grant & ~req;
  assign man_cand  = pending & manual;
  assign auto_cand = pending & ~manual;

  // Slots freed by this edge's releases are usable by this edge's grant.
  assign cap_ok = (32'(on_count) - popcnt(32'(release_v))) < MAX_ON;

  zone_rr_picker #(.N_ZONES(N_ZONES)) u_pick_manual (
    .cand   (man_cand),
    .rr_ptr (rr_q),
    .valid  (man_valid),
    .index  (man_idx)
  );

  zone_rr_picker #(.N_ZONES(N_ZONES)) u_pick_auto (
    .cand   (auto_cand),
    .rr_ptr (rr_q),
    .valid  (auto_valid),
    .index  (auto_idx)
  );

  assign win_valid = man_valid | auto_valid;
  assign win_idx   = man_valid ? man_idx : auto_idx;

  always_comb begin
    state_d = state_q;
    grant_d = grant & req;
    rr_d    = rr_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ARB_IDLE: begin
        if (win_valid && cap_ok) begin
          grant_d[win_idx] = 1'b1;
          rr_d    = (win_idx == ZW'(N_ZONES - 1)) ? '0 : win_idx + ZW'(1);
          cnt_d   = SETTLE_LOAD;
          state_d = ARB_SETTLE;
        end
      end
      ARB_SETTLE: begin
        if (cnt_q == '0) begin
          state_d = ARB_IDLE;
        end else begin
          cnt_d = cnt_q - SW'(1);
        end
      end
      default: state_d = ARB_IDLE;
    endcase
    busy_d     = (state_d == ARB_SETTLE);
    on_count_d = CW'(popcnt(32'(grant_d)));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ARB_IDLE;
      grant    <= '0;
      rr_q     <= '0;
      cnt_q    <= '0;
      busy     <= 1'b0;
      on_count <= '0;
    end else begin
      state_q  <= state_d;
      grant    <= grant_d;
      rr_q     <= rr_d;
      cnt_q    <= cnt_d;
      busy     <= busy_d;
      on_count <= on_count_d;
    end
  end

endmodule

// File: tb/tb_lamp_zone_arbiter.sv
// Scoreboard bench for lamp_zone_arbiter: expected grant rising edges are queued with stimulus.
module tb_lamp_zone_arbiter;

  localparam int ST = 20;

  typedef struct {
    int zone;
    int cyc;
  } ev_t;

  logic       clk, rst;
  logic [3:0] req, manual, grant, pending;
  logic [3:0] req1, manual1, grant1, pending1;
  logic       busy, busy1;
  logic [2:0] on_count, on_count1;

  int  cyc;
  int  n_cmp, n_err;
  ev_t exp_q[$], obs_q[$], obs1_q[$];
  logic [3:0] prev, prev1;

  lamp_zone_arbiter #(.N_ZONES(4), .MAX_ON(2), .STAGGER_T(ST)) dut (
    .clk(clk), .rst(rst), .req(req), .manual(manual),
    .grant(grant), .pending(pending), .busy(busy), .on_count(on_count)
  );

  lamp_zone_arbiter #(.N_ZONES(4), .MAX_ON(1), .STAGGER_T(ST)) dut1 (
    .clk(clk), .rst(rst), .req(req1), .manual(manual1),
    .grant(grant1), .pending(pending1), .busy(busy1), .on_count(on_count1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Grant rising-edge monitor, sampled just after each active edge.
  always @(posedge clk) begin
    #1;
    for (int i = 0; i < 4; i++) begin
      if (grant[i] && !prev[i]) obs_q.push_back('{i, cyc});
      if (grant1[i] && !prev1[i]) obs1_q.push_back('{i, cyc});
    end
    prev  = grant;
    prev1 = grant1;
  end

  task automatic do_reset(input logic [3:0] r_req, input logic [3:0] r_man, output int rel);
    @(negedge clk);
    rst = 1'b1; req = r_req; manual = r_man; req1 = '0; manual1 = '0;
    repeat (2) @(negedge clk);
    obs_q.delete(); obs1_q.delete(); exp_q.delete();
    rst = 1'b0;
    rel = cyc;
  endtask

  task automatic test_reset();
    int r;
    ev_t e, o;
    rst = 1'b1; req = 4'b1111; manual = '0;
    repeat (3) @(negedge clk);
    n_cmp++; if (grant !== 4'b0000) begin n_err++; $display("FAIL reset_grant: got %b want 0000", grant); end
    n_cmp++; if (on_count !== 3'd0) begin n_err++; $display("FAIL reset_on_count: got %0d want 0", on_count); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (pending !== 4'b1111) begin n_err++; $display("FAIL reset_pending: got %b want 1111", pending); end
    obs_q.delete(); exp_q.delete();
    rst = 1'b0; r = cyc;
    exp_q.push_back('{0, r + 1});
    exp_q.push_back('{1, r + 1 + ST});
    repeat (3 * ST) @(negedge clk);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); n_cmp++;
      if (obs_q.size() == 0) begin
        n_err++; $display("FAIL reset_seq: no grant edge, want zone %0d at cycle %0d", e.zone, e.cyc);
      end else begin
        o = obs_q.pop_front();
        if (o.zone !== e.zone || o.cyc !== e.cyc) begin
          n_err++; $display("FAIL reset_seq: got zone %0d cyc %0d want zone %0d cyc %0d", o.zone, o.cyc, e.zone, e.cyc);
        end
      end
    end
    n_cmp++; if (obs_q.size() != 0) begin n_err++; $display("FAIL reset_extra: got %0d extra grant edges want 0", obs_q.size()); end
    n_cmp++; if (grant !== 4'b0011) begin n_err++; $display("FAIL reset_cap_grant: got %b want 0011", grant); end
    n_cmp++; if (on_count !== 3'd2) begin n_err++; $display("FAIL reset_cap_count: got %0d want 2", on_count); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_cap_busy: got %b want 0", busy); end
  endtask

  task automatic test_manual();
    int r;
    ev_t e, o;
    do_reset(4'b0110, 4'b0100, r);
    exp_q.push_back('{2, r + 1});
    exp_q.push_back('{1, r + 1 + ST});
    repeat (2 * ST) @(negedge clk);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); n_cmp++;
      if (obs_q.size() == 0) begin
        n_err++; $display("FAIL manual_seq: no grant edge, want zone %0d at cycle %0d", e.zone, e.cyc);
      end else begin
        o = obs_q.pop_front();
        if (o.zone !== e.zone || o.cyc !== e.cyc) begin
          n_err++; $display("FAIL manual_seq: got zone %0d cyc %0d want zone %0d cyc %0d", o.zone, o.cyc, e.zone, e.cyc);
        end
      end
    end
    n_cmp++; if (on_count !== 3'd2) begin n_err++; $display("FAIL manual_count: got %0d want 2", on_count); end
  endtask

  task automatic test_round_robin();
    int r, w;
    ev_t e, o;
    do_reset(4'b0000, 4'b0000, r);
    req1 = 4'b1011;
    exp_q.push_back('{0, r + 1});
    exp_q.push_back('{1, r + 1 + ST});
    exp_q.push_back('{3, r + 1 + 2 * ST});
    exp_q.push_back('{0, r + 1 + 3 * ST});
    for (int k = 0; k < 4; k++) begin
      w = 0;
      while (obs1_q.size() == 0 && w < ST + 5) begin
        @(negedge clk);
        w++;
      end
      e = exp_q.pop_front(); n_cmp++;
      if (obs1_q.size() == 0) begin
        n_err++; $display("FAIL rr_seq: timeout, want zone %0d at cycle %0d", e.zone, e.cyc);
      end else begin
        o = obs1_q.pop_front();
        if (o.zone !== e.zone || o.cyc !== e.cyc) begin
          n_err++; $display("FAIL rr_seq: got zone %0d cyc %0d want zone %0d cyc %0d", o.zone, o.cyc, e.zone, e.cyc);
        end
      end
      n_cmp++; if (on_count1 !== 3'd1) begin n_err++; $display("FAIL rr_count: got %0d want 1", on_count1); end
      req1 = 4'b1011 & ~(4'(1) << e.zone);
    end
    req1 = '0;
  endtask

  task automatic test_release_grant_same_edge();
    int r, eg;
    ev_t e, o;
    do_reset(4'b0111, 4'b0000, r);
    exp_q.push_back('{0, r + 1});
    exp_q.push_back('{1, r + 1 + ST});
    repeat (2 * ST + 5) @(negedge clk);
    n_cmp++; if (grant !== 4'b0011) begin n_err++; $display("FAIL same_pre_grant: got %b want 0011", grant); end
    n_cmp++; if (pending !== 4'b0100) begin n_err++; $display("FAIL same_pre_pending: got %b want 0100", pending); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL same_pre_busy: got %b want 0", busy); end
    req = 4'b0110;
    eg = cyc + 1;
    exp_q.push_back('{2, eg});
    @(negedge clk);
    n_cmp++; if (grant !== 4'b0110) begin n_err++; $display("FAIL same_edge_grant: got %b want 0110", grant); end
    n_cmp++; if (on_count !== 3'd2) begin n_err++; $display("FAIL same_edge_count: got %0d want 2", on_count); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); n_cmp++;
      if (obs_q.size() == 0) begin
        n_err++; $display("FAIL same_seq: no grant edge, want zone %0d at cycle %0d", e.zone, e.cyc);
      end else begin
        o = obs_q.pop_front();
        if (o.zone !== e.zone || o.cyc !== e.cyc) begin
          n_err++; $display("FAIL same_seq: got zone %0d cyc %0d want zone %0d cyc %0d", o.zone, o.cyc, e.zone, e.cyc);
        end
      end
    end
  endtask

  task automatic test_release_during_stagger();
    int r;
    ev_t e, o;
    do_reset(4'b0011, 4'b0000, r);
    exp_q.push_back('{0, r + 1});
    exp_q.push_back('{1, r + 1 + ST});
    @(negedge clk);
    n_cmp++; if (grant !== 4'b0001 || busy !== 1'b1) begin n_err++; $display("FAIL stag_first: got grant %b busy %b want 0001 1", grant, busy); end
    req = 4'b0010;
    @(negedge clk);
    n_cmp++; if (grant !== 4'b0000 || busy !== 1'b1) begin n_err++; $display("FAIL stag_release: got grant %b busy %b want 0000 1", grant, busy); end
    repeat (ST - 3) @(negedge clk);
    n_cmp++; if (grant !== 4'b0000 || busy !== 1'b1) begin n_err++; $display("FAIL stag_window: got grant %b busy %b want 0000 1", grant, busy); end
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL stag_window_end: got busy %b want 0", busy); end
    repeat (5) @(negedge clk);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); n_cmp++;
      if (obs_q.size() == 0) begin
        n_err++; $display("FAIL stag_seq: no grant edge, want zone %0d at cycle %0d", e.zone, e.cyc);
      end else begin
        o = obs_q.pop_front();
        if (o.zone !== e.zone || o.cyc !== e.cyc) begin
          n_err++; $display("FAIL stag_seq: got zone %0d cyc %0d want zone %0d cyc %0d", o.zone, o.cyc, e.zone, e.cyc);
        end
      end
    end
    n_cmp++; if (grant !== 4'b0010) begin n_err++; $display("FAIL stag_final: got %b want 0010", grant); end
  endtask

  task automatic test_async_reset();
    int r, r2;
    ev_t e, o;
    do_reset(4'b1111, 4'b0000, r);
    exp_q.push_back('{0, r + 1});
    exp_q.push_back('{1, r + 1 + ST});
    repeat (ST + 5) @(negedge clk);
    n_cmp++; if (grant !== 4'b0011 || busy !== 1'b1) begin n_err++; $display("FAIL async_pre: got grant %b busy %b want 0011 1", grant, busy); end
    #2 rst = 1'b1;
    #1;
    n_cmp++; if (grant !== 4'b0000) begin n_err++; $display("FAIL async_grant: got %b want 0000", grant); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL async_busy: got %b want 0", busy); end
    n_cmp++; if (on_count !== 3'd0) begin n_err++; $display("FAIL async_count: got %0d want 0", on_count); end
    @(negedge clk);
    rst = 1'b0;
    r2 = cyc;
    exp_q.push_back('{0, r2 + 1});
    repeat (3) @(negedge clk);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); n_cmp++;
      if (obs_q.size() == 0) begin
        n_err++; $display("FAIL async_seq: no grant edge, want zone %0d at cycle %0d", e.zone, e.cyc);
      end else begin
        o = obs_q.pop_front();
        if (o.zone !== e.zone || o.cyc !== e.cyc) begin
          n_err++; $display("FAIL async_seq: got zone %0d cyc %0d want zone %0d cyc %0d", o.zone, o.cyc, e.zone, e.cyc);
        end
      end
    end
    n_cmp++; if (grant !== 4'b0001) begin n_err++; $display("FAIL async_restart: got %b want 0001", grant); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    cyc = 0; n_cmp = 0; n_err = 0;
    prev = '0; prev1 = '0;
    rst = 1'b1; req = '0; manual = '0; req1 = '0; manual1 = '0;
    test_reset();
    test_manual();
    test_round_robin();
    test_release_grant_same_edge();
    test_release_during_stagger();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
